// File: rtl/dcache_stream_prefetcher.sv
// -----------------------------------------------------------------------------
// dcache_stream_prefetcher
//
// Multi-stream prefetch buffer that sits beside the dcache data array.
// A read miss that matches no stream allocates one (tree pseudo-LRU victim).
// That stream then fetches consecutive 8-byte blocks from memory over the
// tagged bus. A later miss on a VALID buffered block is refilled into the
// cache one cycle later, and that entry plus all older entries are dropped.
// A store to a buffered block kills the whole stream.
//
// Optional feature: define DCACHE_PF_STRIDE_EN to learn a signed stride
// (|d| <= MAX_STRIDE blocks) from consecutive allocation addresses. Without
// it, every stream walks forward with stride +1.
//
// Ports
//   clock, reset            clock; asynchronous active-low reset
//   miss_valid, miss_addr   dcache read miss (block = miss_addr[31:3])
//   wr_valid, wr_addr       processor store, used for invalidation
//   lookup_hit              combinational: miss block is VALID in a stream
//   lookup_pending          combinational: miss block is only PENDING
//   fill_valid/addr/data    registered one-cycle refill into the cache
//   proc2Dmem_command/addr  prefetch request (BUS_NONE / BUS_LOAD)
//   Dmem2proc_response      nonzero: request accepted with this tag
//   Dmem2proc_data/tag      returned data for a nonzero tag
// -----------------------------------------------------------------------------
module dcache_stream_prefetcher #(
    parameter int NUM_STREAMS = 4,
    parameter int DEPTH       = 4,
    parameter int MAX_STRIDE  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        miss_valid,
    input  logic [63:0] miss_addr,
    input  logic        wr_valid,
    input  logic [63:0] wr_addr,
    output logic        lookup_hit,
    output logic        lookup_pending,
    output logic        fill_valid,
    output logic [63:0] fill_addr,
    output logic [63:0] fill_data,
    output logic [1:0]  proc2Dmem_command,
    output logic [63:0] proc2Dmem_addr,
    input  logic [3:0]  Dmem2proc_response,
    input  logic [63:0] Dmem2proc_data,
    input  logic [3:0]  Dmem2proc_tag
);
    localparam int SW = $clog2(NUM_STREAMS);
    localparam int KW = $clog2(DEPTH);
    localparam int TW = $clog2(DEPTH + 1);
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [1:0] {ENT_EMPTY, ENT_PENDING, ENT_VALID} ent_t;
    typedef enum logic {STRM_IDLE, STRM_ACTIVE} strm_t;

    strm_t         state_reg     [NUM_STREAMS];
    strm_t         state_next    [NUM_STREAMS];
    logic [28:0]   next_blk_reg  [NUM_STREAMS];
    logic [28:0]   next_blk_next [NUM_STREAMS];
    logic [28:0]   stride_reg    [NUM_STREAMS];
    logic [28:0]   stride_next   [NUM_STREAMS];
    logic [TW-1:0] tail_reg      [NUM_STREAMS];
    logic [TW-1:0] tail_next     [NUM_STREAMS];
    ent_t          ent_reg       [NUM_STREAMS][DEPTH];
    ent_t          ent_next      [NUM_STREAMS][DEPTH];
    logic [28:0]   blk_reg       [NUM_STREAMS][DEPTH];
    logic [28:0]   blk_next      [NUM_STREAMS][DEPTH];
    logic [3:0]    tag_reg       [NUM_STREAMS][DEPTH];
    logic [3:0]    tag_next      [NUM_STREAMS][DEPTH];
    logic [63:0]   data_reg      [NUM_STREAMS][DEPTH];
    logic [63:0]   data_next     [NUM_STREAMS][DEPTH];
    // Heap-ordered PLRU tree: node n has children 2n and 2n+1, leaves are
    // NUM_STREAMS..2*NUM_STREAMS-1. A node bit of 1 means the right side is
    // the least recently used one.
    logic [NUM_STREAMS-1:1] plru_reg, plru_next;
    logic [SW-1:0]          rr_reg, rr_next;

    logic [28:0]            miss_blk, wr_blk, alloc_stride;
    logic                   hit, pend, alloc, issue, accept;
    logic [SW-1:0]          hit_s, victim, issue_s, cand;
    logic [KW-1:0]          hit_k, wpos;
    logic [63:0]            hit_data;
    logic [NUM_STREAMS-1:0] inval;
    int                     node, src;
    logic                   unused_bits;

    assign miss_blk    = miss_addr[31:3];
    assign wr_blk      = wr_addr[31:3];
    assign unused_bits = ^{miss_addr[63:32], miss_addr[2:0], wr_addr[63:32], wr_addr[2:0]};

`ifdef DCACHE_PF_STRIDE_EN
    logic [28:0] last_miss_reg, stride_diff, stride_mag;

    always_comb begin
        stride_diff  = miss_blk - last_miss_reg;
        stride_mag   = stride_diff[28] ? (~stride_diff + 29'd1) : stride_diff;
        alloc_stride = 29'd1;
        // A negative stride is kept in two's complement so next_blk wraps mod 2^29.
        if (stride_mag != 29'd0 && stride_mag <= 29'(MAX_STRIDE))
            alloc_stride = stride_diff;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            last_miss_reg <= '0;
        else if (alloc)
            last_miss_reg <= miss_blk;
    end
`else
    // MAX_STRIDE only matters when stride learning is compiled in.
    localparam int UNUSED_MAX_STRIDE = MAX_STRIDE;
    assign alloc_stride = 29'd1;
`endif

    // Lookup and store-invalidate match. Descending scan so the last match
    // written is the lowest stream, then the lowest entry.
    always_comb begin
        hit      = 1'b0;
        pend     = 1'b0;
        hit_s    = '0;
        hit_k    = '0;
        hit_data = '0;
        inval    = '0;
        for (int s = NUM_STREAMS - 1; s >= 0; s--) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (state_reg[s] == STRM_ACTIVE && ent_reg[s][k] != ENT_EMPTY) begin
                    if (miss_valid && blk_reg[s][k] == miss_blk) begin
                        if (ent_reg[s][k] == ENT_VALID) begin
                            hit      = 1'b1;
                            hit_s    = SW'(s);
                            hit_k    = KW'(k);
                            hit_data = data_reg[s][k];
                        end else begin
                            pend = 1'b1;
                        end
                    end
                    if (wr_valid && blk_reg[s][k] == wr_blk)
                        inval[s] = 1'b1;
                end
            end
        end
    end

    assign lookup_hit     = hit;
    assign lookup_pending = pend && !hit;
    assign alloc          = miss_valid && !hit && !pend;

    // PLRU victim: walk from the root following the LRU bits.
    always_comb begin
        node = 1;
        for (int l = 0; l < SW; l++)
            node = 2 * node + (plru_reg[node[SW-1:0]] ? 1 : 0);
        victim = node[SW-1:0];
    end

    function automatic logic [NUM_STREAMS-1:1] plru_touch(
        input logic [NUM_STREAMS-1:1] bits,
        input logic [SW-1:0]          s
    );
        int idx;
        int parent;
        idx = NUM_STREAMS + int'(s);
        for (int l = 0; l < SW; l++) begin
            parent = idx >> 1;
            // Point the parent away from the child we came from.
            bits[parent[SW-1:0]] = ~idx[0];
            idx = parent;
        end
        return bits;
    endfunction

    // Round-robin issue: first eligible stream at or after rr_reg.
    always_comb begin
        issue   = 1'b0;
        issue_s = '0;
        cand    = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            cand = rr_reg + SW'(i);
            if (state_reg[cand] == STRM_ACTIVE && tail_reg[cand] != TW'(DEPTH)) begin
                issue   = 1'b1;
                issue_s = cand;
            end
        end
    end

    assign accept            = issue && (Dmem2proc_response != 4'd0);
    assign proc2Dmem_command = issue ? BUS_LOAD : BUS_NONE;
    assign proc2Dmem_addr    = issue ? {32'b0, next_blk_reg[issue_s], 3'b0} : 64'd0;

    always_comb begin
        state_next    = state_reg;
        next_blk_next = next_blk_reg;
        stride_next   = stride_reg;
        tail_next     = tail_reg;
        ent_next      = ent_reg;
        blk_next      = blk_reg;
        tag_next      = tag_reg;
        data_next     = data_reg;
        plru_next     = plru_reg;
        rr_next       = rr_reg;
        wpos          = '0;
        src           = 0;
        for (int s = 0; s < NUM_STREAMS; s++) begin
            if (alloc && victim == SW'(s)) begin
                // Allocation overrides any same-cycle acceptance or return.
                state_next[s]    = STRM_ACTIVE;
                next_blk_next[s] = miss_blk + alloc_stride;
                stride_next[s]   = alloc_stride;
                tail_next[s]     = '0;
                for (int k = 0; k < DEPTH; k++)
                    ent_next[s][k] = ENT_EMPTY;
            end else if (inval[s]) begin
                state_next[s] = STRM_IDLE;
                tail_next[s]  = '0;
                for (int k = 0; k < DEPTH; k++)
                    ent_next[s][k] = ENT_EMPTY;
            end else begin
                if (hit && hit_s == SW'(s)) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        src = k + int'(hit_k) + 1;
                        if (src < DEPTH) begin
                            ent_next[s][k]  = ent_reg[s][src[KW-1:0]];
                            blk_next[s][k]  = blk_reg[s][src[KW-1:0]];
                            tag_next[s][k]  = tag_reg[s][src[KW-1:0]];
                            data_next[s][k] = data_reg[s][src[KW-1:0]];
                        end else begin
                            ent_next[s][k] = ENT_EMPTY;
                        end
                    end
                    tail_next[s] = tail_reg[s] - (TW'(hit_k) + TW'(1));
                end
                if (accept && issue_s == SW'(s)) begin
                    // tail < DEPTH here, so it fits the entry index.
                    wpos                = tail_next[s][KW-1:0];
                    ent_next[s][wpos]   = ENT_PENDING;
                    blk_next[s][wpos]   = next_blk_reg[s];
                    tag_next[s][wpos]   = Dmem2proc_response;
                    tail_next[s]        = tail_next[s] + TW'(1);
                    next_blk_next[s]    = next_blk_reg[s] + stride_reg[s];
                end
                // Returned data is matched by tag after any dequeue shift.
                if (Dmem2proc_tag != 4'd0) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (ent_next[s][k] == ENT_PENDING && tag_next[s][k] == Dmem2proc_tag) begin
                            ent_next[s][k]  = ENT_VALID;
                            data_next[s][k] = Dmem2proc_data;
                        end
                    end
                end
            end
        end
        if (accept)
            rr_next = issue_s + SW'(1);
        if (hit)
            plru_next = plru_touch(plru_reg, hit_s);
        else if (alloc)
            plru_next = plru_touch(plru_reg, victim);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_STREAMS; s++) begin
                state_reg[s]    <= STRM_IDLE;
                next_blk_reg[s] <= '0;
                stride_reg[s]   <= '0;
                tail_reg[s]     <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    ent_reg[s][k]  <= ENT_EMPTY;
                    blk_reg[s][k]  <= '0;
                    tag_reg[s][k]  <= '0;
                    data_reg[s][k] <= '0;
                end
            end
            plru_reg   <= '0;
            rr_reg     <= '0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_data  <= '0;
        end else begin
            state_reg    <= state_next;
            next_blk_reg <= next_blk_next;
            stride_reg   <= stride_next;
            tail_reg     <= tail_next;
            ent_reg      <= ent_next;
            blk_reg      <= blk_next;
            tag_reg      <= tag_next;
            data_reg     <= data_next;
            plru_reg     <= plru_next;
            rr_reg       <= rr_next;
            fill_valid   <= hit;
            if (hit) begin
                fill_addr <= {32'b0, miss_blk, 3'b0};
                fill_data <= hit_data;
            end
        end
    end
endmodule
